// File: rtl/common.sv
// common: slot-order types shared by the TDM select sequencer and deserializer
package common;
    localparam int NUM_SLOTS = 4;
    typedef logic [1:0] slot_t;
    typedef enum logic {HUNT, FRAME} deser_states;
endpackage

// File: rtl/slot_seq_check.sv
// slot_seq_check: tracks the expected slot and flags stores, frame completion and order errors
module slot_seq_check
    import common::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  valid_i,
    input  slot_t slot_i,
    output logic  store_o,
    output logic  frame_done_o,
    output logic  err_o
);
    deser_states state_q, state_d;
    slot_t exp_q, exp_d;
    logic in_frame;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= HUNT;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
        end

    // slot 0 always (re)starts a frame, whatever state we are in
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        if (valid_i) begin
            state_d = (slot_i == '0 || (in_frame && slot_i == exp_q)) ? FRAME : HUNT;
            exp_d   = (slot_i == '0) ? slot_t'(1) :
                      (in_frame && slot_i == exp_q) ? slot_t'(exp_q + 2'd1) : '0;
        end
    end

    always_comb begin
        in_frame     = state_q == FRAME;
        store_o      = valid_i && (slot_i == '0 || (in_frame && slot_i == exp_q && slot_i != 2'd3));
        frame_done_o = valid_i && in_frame && slot_i == 2'd3 && exp_q == 2'd3;
        err_o        = valid_i && in_frame && slot_i != exp_q;
    end
endmodule

// File: rtl/tdm_slot_deser.sv
// tdm_slot_deser: reassembles in-order 4-slot TDM beats into frames and tracks sync/errors
module tdm_slot_deser
    import common::*;
#(
    parameter int DATA_W      = 8,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  slot_t                 in_slot,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    output logic [4*DATA_W-1:0]   out_word,
    output logic                  locked,
    output logic                  seq_err,
    output logic [7:0]            err_count
);
    logic store, frame_done, err;
    logic [(NUM_SLOTS-1)*DATA_W-1:0] lane_q;
    logic [3:0] good_q;

    slot_seq_check u_chk (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (in_valid),
        .slot_i       (in_slot),
        .store_o      (store),
        .frame_done_o (frame_done),
        .err_o        (err)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lane_q    <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            seq_err   <= 1'b0;
            err_count <= '0;
            good_q    <= '0;
            locked    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_SLOTS - 1; k++)
                if (store && in_slot == slot_t'(k))
                    lane_q[k*DATA_W +: DATA_W] <= in_data;
            if (frame_done)
                out_word <= {in_data, lane_q};
            out_valid <= frame_done;
            seq_err   <= err;
            if (err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            // locked rises together with the out_valid of the LOCK_FRAMES-th good frame
            if (err) begin
                good_q <= '0;
                locked <= 1'b0;
            end else if (frame_done) begin
                if (good_q != 4'(LOCK_FRAMES))
                    good_q <= good_q + 4'd1;
                if ({1'b0, good_q} + 5'd1 >= 5'(LOCK_FRAMES))
                    locked <= 1'b1;
            end
        end
endmodule

// File: tb/tb_tdm_slot_deser.sv
// tb_tdm_slot_deser: directed vectors with hand-computed frames, lock and error behaviour
module tb_tdm_slot_deser;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_slot = '0;
    logic [7:0]  in_data = '0;
    logic        out_valid, locked, seq_err;
    logic [31:0] out_word;
    logic [7:0]  err_count;
    int vectors = 0, miscompares = 0;
    int nov = 0, nse = 0;

    tdm_slot_deser #(.DATA_W(8), .LOCK_FRAMES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_slot   (in_slot),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_word  (out_word),
        .locked    (locked),
        .seq_err   (seq_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (out_valid) nov++;
        if (seq_err) nse++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [1:0] s, input logic [7:0] d);
        in_valid = 1'b1;
        in_slot  = s;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        nov = 0;
        nse = 0;
    endtask

    initial begin
        int ov0, se0;
        idle(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        idle(1);

        // clean stream, two frames
        send(0, 8'h11); send(1, 8'h22); send(2, 8'h33);
        chk("clean_no_early_valid", 32'(nov), 32'd0);
        send(3, 8'h44);
        chk("clean1_valid", 32'(out_valid), 32'd1);
        chk("clean1_word", out_word, 32'h44332211);
        chk("clean1_unlocked", 32'(locked), 32'd0);
        send(0, 8'h55);
        chk("clean1_pulse_one_cycle", 32'(out_valid), 32'd0);
        send(1, 8'h66); send(2, 8'h77);
        chk("clean_word_holds", out_word, 32'h44332211);
        send(3, 8'h88);
        chk("clean2_valid", 32'(out_valid), 32'd1);
        chk("clean2_word", out_word, 32'h88776655);
        chk("clean2_locked", 32'(locked), 32'd1);
        idle(1);
        chk("clean_frames", 32'(nov), 32'd2);
        chk("clean_no_seq_err", 32'(nse), 32'd0);

        // order error while locked: 0,1,3
        ov0 = nov;
        send(0, 8'hA0); send(1, 8'hA1); send(3, 8'hA3);
        chk("err_seq_err", 32'(seq_err), 32'd1);
        chk("err_count1", 32'(err_count), 32'd1);
        chk("err_unlock", 32'(locked), 32'd0);
        chk("err_no_valid", 32'(nov - ov0), 32'd0);
        se0 = nse;
        send(2, 8'hB2); send(3, 8'hB3);
        chk("err_in_hunt_silent", 32'(nse - se0), 32'd0);
        chk("err_in_hunt_no_valid", 32'(nov - ov0), 32'd0);

        // restart on early slot 0: 0,1,0,1,2,3
        ov0 = nov; se0 = nse;
        send(0, 8'hC0); send(1, 8'hC1); send(0, 8'hD0);
        send(1, 8'hD1); send(2, 8'hD2); send(3, 8'hD3);
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_word", out_word, 32'hD3D2D1D0);
        chk("restart_one_err", 32'(nse - se0), 32'd1);
        chk("restart_count2", 32'(err_count), 32'd2);
        chk("restart_one_frame", 32'(nov - ov0), 32'd1);

        // hunt after reset: 2,3,0,1,2,3
        do_reset();
        send(2, 8'h01); send(3, 8'h02); send(0, 8'h03);
        send(1, 8'h04); send(2, 8'h05); send(3, 8'h06);
        chk("hunt_word", out_word, 32'h06050403);
        chk("hunt_frames", 32'(nov), 32'd1);
        chk("hunt_no_err", 32'(nse), 32'd0);

        // gapped input, 0..3 idles between beats
        do_reset();
        send(0, 8'h11); send(1, 8'h22); idle(1);
        send(2, 8'h33); idle(2);
        send(3, 8'h44);
        chk("gap0_valid", 32'(out_valid), 32'd1);
        chk("gap0_word", out_word, 32'h44332211);
        send(0, 8'h55); idle(3);
        send(1, 8'h66); idle(1);
        send(2, 8'h77); idle(3);
        chk("gap_stall_no_valid", 32'(nov), 32'd1);
        send(3, 8'h88);
        chk("gap1_valid", 32'(out_valid), 32'd1);
        chk("gap1_word", out_word, 32'h88776655);
        chk("gap1_locked", 32'(locked), 32'd1);
        chk("gap_no_err", 32'(nse), 32'd0);

        // error counter saturation
        do_reset();
        for (int i = 0; i < 255; i++) begin send(0, 8'h00); send(2, 8'h00); end
        chk("sat_255", 32'(err_count), 32'd255);
        for (int i = 0; i < 5; i++) begin send(0, 8'h00); send(2, 8'h00); end
        chk("sat_hold", 32'(err_count), 32'd255);
        chk("sat_pulses", 32'(nse), 32'd260);

        // asynchronous reset mid-frame
        do_reset();
        send(0, 8'h11); send(1, 8'h22); send(2, 8'h33); send(3, 8'h44);
        send(0, 8'h55); send(1, 8'h66); send(2, 8'h77); send(3, 8'h88);
        send(0, 8'h99); send(1, 8'hAA);
        chk("pre_rst_locked", 32'(locked), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_word", out_word, 32'd0);
        chk("async_rst_locked", 32'(locked), 32'd0);
        chk("async_rst_count", 32'(err_count), 32'd0);
        tick();
        rst = 1'b0;
        nov = 0; nse = 0;
        send(2, 8'hBB); send(3, 8'hCC);
        chk("post_rst_no_valid", 32'(nov), 32'd0);
        chk("post_rst_no_err", 32'(nse), 32'd0);
        send(0, 8'h01); send(1, 8'h02); send(2, 8'h03); send(3, 8'h04);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_word", out_word, 32'h04030201);
        chk("post_rst_unlocked", 32'(locked), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
